// File: rtl/udp_pkg.sv
// Shared state encoding, checksum length and checksum helper for the UDP command dispatcher.
package udp_pkg;

   typedef enum logic [1:0] {IDLE, RECV, DISP, DROP} state_t;

   localparam int CSUM_LEN = 1;

   function automatic logic [7:0] csum_xor(input logic [7:0] acc, input logic [7:0] b);
      return acc ^ b;
   endfunction

endpackage

// File: rtl/udp_dispatch_timer.sv
// Dispatch wait counter: restarts at 0 on start, stops on clear, flags expire at TIMEOUT-1.
module udp_dispatch_timer #(
   parameter int TIMEOUT = 1024
) (
   input  logic clk,
   input  logic rst,
   input  logic start,
   input  logic clear,
   output logic expire
);

   logic [15:0] cnt;
   logic        run;

   assign expire = run && (cnt == 16'(TIMEOUT - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
         run <= 1'b0;
      end else if (start) begin
         cnt <= '0;
         run <= 1'b1;
      end else if (clear) begin
         cnt <= '0;
         run <= 1'b0;
      end else if (run && !expire) begin
         cnt <= cnt + 16'd1;
      end
   end

endmodule

// File: rtl/udp_cmd_dispatch.sv
// Collects a target-id/payload frame from a UDP byte stream and hands it to one target.
// Define UDP_DISPATCH_CSUM_EN to expect and verify a trailing XOR checksum byte.
module udp_cmd_dispatch
   import udp_pkg::*;
#(
   parameter int N_TGT   = 4,
   parameter int PLEN    = 4,
   parameter int TIMEOUT = 1024
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              valid,
   input  logic              rx_end,
   input  logic [7:0]        i_data,
   output logic [PLEN*8-1:0] o_data,
   output logic [N_TGT-1:0]  o_valid,
   input  logic [N_TGT-1:0]  i_ready,
   output logic              busy,
   output logic              err_len,
   output logic              err_tgt,
   output logic              err_csum,
   output logic [15:0]       drop_cnt
);

`ifdef UDP_DISPATCH_CSUM_EN
   localparam int EXP = PLEN + 1 + CSUM_LEN;
`else
   localparam int EXP = PLEN + 1;
`endif

   state_t            state, state_d;
   logic [7:0]        cnt, cnt_d, tgt, tgt_d;
   logic [PLEN*8-1:0] pay, pay_d;
   logic              ovr, ovr_d;
   logic              csum_ok, eof, hs, expire, tmr_start, tmr_clear;
   logic              len_e, tgt_e, cs_e, drop_inc;

   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   // Byte capture: values as they stand after this cycle's byte, so a byte
   // arriving together with rx_end is counted before the frame is judged.
   always_comb begin
      cnt_d = cnt;
      tgt_d = tgt;
      pay_d = pay;
      if (valid && state == IDLE) begin
         tgt_d = i_data;
         cnt_d = 8'd1;
      end else if (valid && state == RECV) begin
         if (cnt <= 8'(EXP)) cnt_d = cnt + 8'd1;
         for (int k = 0; k < PLEN; k++)
            if (cnt == 8'(k + 1)) pay_d[8*(PLEN-1-k) +: 8] = i_data;
      end
   end

`ifdef UDP_DISPATCH_CSUM_EN
   logic [7:0] csum, csum_d, rxcs, rxcs_d;

   always_comb begin
      csum_d = csum;
      rxcs_d = rxcs;
      if (valid && state == IDLE) begin
         csum_d = i_data;
      end else if (valid && state == RECV) begin
         if (cnt <= 8'(PLEN))          csum_d = csum_xor(csum, i_data);
         else if (cnt == 8'(PLEN + 1)) rxcs_d = i_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         csum     <= '0;
         rxcs     <= '0;
         err_csum <= 1'b0;
      end else begin
         csum     <= csum_d;
         rxcs     <= rxcs_d;
         err_csum <= cs_e;
      end
   end

   assign csum_ok = (csum_d == rxcs_d);
`else
   assign csum_ok  = 1'b1;
   assign err_csum = 1'b0;
`endif

   always_comb begin
      for (int i = 0; i < N_TGT; i++)
         o_valid[i] = (state == DISP) && (tgt == 8'(i));
   end

   assign o_data = pay;
   assign busy   = (state != IDLE);
   assign eof    = rx_end && ((state == RECV) || (state == IDLE && valid));
   assign hs     = (state == DISP) && ((o_valid & i_ready) != '0);

   // Control: state transitions, error pulses and drop accounting
   always_comb begin
      state_d   = state;
      ovr_d     = ovr;
      len_e     = 1'b0;
      tgt_e     = 1'b0;
      cs_e      = 1'b0;
      drop_inc  = 1'b0;
      tmr_start = 1'b0;
      tmr_clear = 1'b0;
      unique case (state)
         IDLE: begin
            if (valid)       state_d = RECV;
            else if (rx_end) len_e   = 1'b1;
         end
         DISP: begin
            if (valid) ovr_d = 1'b1;
            if (rx_end) begin
               ovr_d    = 1'b0;
               drop_inc = 1'b1;
            end
            if (hs || expire) begin
               state_d   = ovr_d ? DROP : IDLE;
               ovr_d     = 1'b0;
               tmr_clear = 1'b1;
               tgt_e     = !hs;
            end
         end
         DROP: begin
            if (rx_end) begin
               state_d  = IDLE;
               drop_inc = 1'b1;
            end
         end
         default: ;
      endcase
      if (eof) begin
         state_d = IDLE;
         if (cnt_d != 8'(EXP))           len_e = 1'b1;
         else if (tgt_d >= 8'(N_TGT))    tgt_e = 1'b1;
         else if (!csum_ok)              cs_e  = 1'b1;
         else begin
            state_d   = DISP;
            tmr_start = 1'b1;
         end
      end
      drop_inc = drop_inc | len_e | tgt_e | cs_e;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         cnt      <= '0;
         tgt      <= '0;
         pay      <= '0;
         ovr      <= 1'b0;
         err_len  <= 1'b0;
         err_tgt  <= 1'b0;
         drop_cnt <= '0;
      end else begin
         state   <= state_d;
         cnt     <= cnt_d;
         tgt     <= tgt_d;
         pay     <= pay_d;
         ovr     <= ovr_d;
         err_len <= len_e;
         err_tgt <= tgt_e;
         if (drop_inc) drop_cnt <= sat_inc(drop_cnt);
      end
   end

   udp_dispatch_timer #(.TIMEOUT(TIMEOUT)) u_timer (
      .clk    (clk),
      .rst    (rst),
      .start  (tmr_start),
      .clear  (tmr_clear),
      .expire (expire)
   );

endmodule

// File: tb/tb_udp_cmd_dispatch.sv
// Self-checking bench for udp_cmd_dispatch: frame table plus hand-written corner sequences,
// with an event scoreboard fed at stimulus time and drained by an output monitor.
module tb_udp_cmd_dispatch;

   localparam int NT = 4, PL = 4, TO = 20;
   localparam int K_DISP = 0, K_LEN = 1, K_TGT = 2, K_CSUM = 3;
`ifdef UDP_DISPATCH_CSUM_EN
   localparam bit CSUM = 1'b1;
`else
   localparam bit CSUM = 1'b0;
`endif

   logic            clk = 1'b0, rst = 1'b1, valid = 1'b0, rx_end = 1'b0;
   logic [7:0]      i_data = 8'h00;
   logic [PL*8-1:0] o_data;
   logic [NT-1:0]   o_valid;
   logic [NT-1:0]   i_ready = '0;
   logic            busy, err_len, err_tgt, err_csum;
   logic [15:0]     drop_cnt;

   typedef struct { int kind; logic [NT-1:0] vld; logic [31:0] data; } exp_t;
   typedef struct { logic [7:0] tgt; int npay; logic [31:0] pay; int dly; bit same; int kind; } vec_t;

   exp_t exp_q[$];
   vec_t vecs[10];
   int   n_chk = 0, n_err = 0, vld_run = 0, exp_drop = 0;

   always #5 clk = ~clk;

   udp_cmd_dispatch #(.N_TGT(NT), .PLEN(PL), .TIMEOUT(TO)) dut (
      .clk      (clk),
      .rst      (rst),
      .valid    (valid),
      .rx_end   (rx_end),
      .i_data   (i_data),
      .o_data   (o_data),
      .o_valid  (o_valid),
      .i_ready  (i_ready),
      .busy     (busy),
      .err_len  (err_len),
      .err_tgt  (err_tgt),
      .err_csum (err_csum),
      .drop_cnt (drop_cnt)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [NT-1:0] oh(input int t);
      return NT'(1) << t;
   endfunction

   task automatic note(input int kind);
      exp_t e;
      if (exp_q.size() == 0) begin
         n_chk++;
         n_err++;
         $display("FAIL unexpected_event: got kind %0d expected none", kind);
      end else begin
         e = exp_q.pop_front();
         check("event_kind", 64'(kind), 64'(e.kind));
         if (kind == K_DISP && e.kind == K_DISP) begin
            check("o_valid", 64'(o_valid), 64'(e.vld));
            check("o_data", 64'(o_data), 64'(e.data));
         end
      end
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         if (o_valid != '0) vld_run++;
         if ((o_valid & i_ready) != '0) note(K_DISP);
         if (err_len)  note(K_LEN);
         if (err_tgt)  note(K_TGT);
         if (err_csum) note(K_CSUM);
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic put_byte(input logic [7:0] b, input bit e);
      valid  = 1'b1;
      i_data = b;
      rx_end = e;
      cyc();
      valid  = 1'b0;
      rx_end = 1'b0;
   endtask

   task automatic pulse_end();
      rx_end = 1'b1;
      cyc();
      rx_end = 1'b0;
   endtask

   task automatic expect_ev(input int kind, input int t, input logic [31:0] d);
      exp_t e;
      e.kind = kind;
      e.vld  = (kind == K_DISP) ? oh(t) : '0;
      e.data = d;
      exp_q.push_back(e);
      if (kind != K_DISP) exp_drop++;
   endtask

   task automatic send_frame(input logic [7:0] t, input int npay, input logic [31:0] pay,
                             input bit bad_cs, input bit same);
      logic [7:0]  fb[$];
      logic [7:0]  cs, b;
      logic [31:0] p;
      p  = pay;
      cs = t;
      fb.push_back(t);
      for (int k = 0; k < npay; k++) begin
         if (k < 4) b = p[31-8*k -: 8];
         else       b = 8'h99;
         fb.push_back(b);
         cs = cs ^ b;
      end
      if (CSUM) fb.push_back(bad_cs ? ~cs : cs);
      for (int i = 0; i < fb.size(); i++) put_byte(fb[i], same && (i == fb.size() - 1));
      if (!same) pulse_end();
   endtask

   task automatic serve(input int t, input int dly);
      int w;
      w = 0;
      while (o_valid == '0 && w < 8) begin
         cyc();
         w++;
      end
      check("valid_seen", 64'(o_valid != '0), 64'd1);
      i_ready = ~oh(t);
      repeat (dly) cyc();
      i_ready = oh(t);
      cyc();
      i_ready = '0;
   endtask

   task automatic drain(input int max);
      int i;
      i = 0;
      while (exp_q.size() != 0 && i < max) begin
         cyc();
         i++;
      end
      check("queue_drained", 64'(exp_q.size()), 64'd0);
      exp_q.delete();
      cyc();
      cyc();
   endtask

   task automatic run_disp(input int t, input logic [31:0] d, input int dly);
      vld_run = 0;
      expect_ev(K_DISP, t, d);
      send_frame(8'(t), PL, d, 1'b0, 1'b0);
      serve(t, dly);
      drain(8);
      check("disp_cycles", 64'(vld_run), 64'(dly + 1));
      check("drop_cnt", 64'(drop_cnt), 64'(exp_drop));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = '{8'h02, 4, 32'h11223344, 3, 1'b0, K_DISP};
      vecs[1] = '{8'h01, 2, 32'h11220000, 0, 1'b0, K_LEN};
      vecs[2] = '{8'h07, 4, 32'h01020304, 0, 1'b0, K_TGT};
      vecs[3] = '{8'h00, 4, 32'hA5A55A5A, 0, 1'b0, K_DISP};
      vecs[4] = '{8'h03, 4, 32'hDEADBEEF, 1, 1'b1, K_DISP};
      vecs[5] = '{8'h04, 4, 32'hCAFEF00D, 0, 1'b0, K_TGT};
      vecs[6] = '{8'h01, 5, 32'h01020304, 0, 1'b0, K_LEN};
      vecs[7] = '{8'h02, 0, 32'h00000000, 0, 1'b0, K_LEN};
      vecs[8] = '{8'h01, 4, 32'h0F1E2D3C, 2, 1'b1, K_DISP};
      vecs[9] = '{8'h03, 3, 32'hAABBCC00, 0, 1'b1, K_LEN};

      repeat (3) @(posedge clk);
      #1;
      check("rst_o_valid", 64'(o_valid), 64'd0);
      check("rst_o_data", 64'(o_data), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_err", 64'({err_len, err_tgt, err_csum}), 64'd0);
      check("rst_drop_cnt", 64'(drop_cnt), 64'd0);
      rst = 1'b0;
      cyc();

      // rx_end with no frame in progress
      expect_ev(K_LEN, 0, 32'h0);
      pulse_end();
      drain(8);
      check("idle_end_drop", 64'(drop_cnt), 64'(exp_drop));

      for (int i = 0; i < 10; i++) begin
         vld_run = 0;
         expect_ev(vecs[i].kind, int'(vecs[i].tgt), vecs[i].pay);
         send_frame(vecs[i].tgt, vecs[i].npay, vecs[i].pay, 1'b0, vecs[i].same);
         if (vecs[i].kind == K_DISP) serve(int'(vecs[i].tgt), vecs[i].dly);
         drain(8);
         check("vec_vld_cycles", 64'(vld_run), 64'((vecs[i].kind == K_DISP) ? vecs[i].dly + 1 : 0));
         check("vec_drop_cnt", 64'(drop_cnt), 64'(exp_drop));
         check("vec_busy", 64'(busy), 64'd0);
      end

      // No ready: o_valid holds for exactly TO cycles, then err_tgt
      vld_run = 0;
      expect_ev(K_TGT, 0, 32'h0);
      send_frame(8'h00, PL, 32'h55667788, 1'b0, 1'b0);
      drain(TO + 10);
      check("timeout_vld_cycles", 64'(vld_run), 64'(TO));
      check("timeout_drop_cnt", 64'(drop_cnt), 64'(exp_drop));
      check("timeout_busy", 64'(busy), 64'd0);

      // Second frame arrives during DISP; ready lands mid-frame
      vld_run = 0;
      expect_ev(K_DISP, 1, 32'h01020304);
      send_frame(8'h01, PL, 32'h01020304, 1'b0, 1'b0);
      put_byte(8'h02, 1'b0);
      put_byte(8'h55, 1'b0);
      valid   = 1'b1;
      i_data  = 8'h66;
      i_ready = oh(1);
      cyc();
      valid   = 1'b0;
      i_ready = '0;
      check("drop_state_busy", 64'(busy), 64'd1);
      put_byte(8'h77, 1'b0);
      put_byte(8'h88, 1'b0);
      pulse_end();
      exp_drop++;
      drain(8);
      check("overrun_vld_cycles", 64'(vld_run), 64'd3);
      check("overrun_drop_cnt", 64'(drop_cnt), 64'(exp_drop));
      check("overrun_busy", 64'(busy), 64'd0);
      run_disp(2, 32'h13572468, 1);

      // rx_end alone while dispatching counts a drop but keeps the command
      expect_ev(K_DISP, 3, 32'hFEDCBA98);
      send_frame(8'h03, PL, 32'hFEDCBA98, 1'b0, 1'b0);
      pulse_end();
      exp_drop++;
      serve(3, 1);
      drain(8);
      check("disp_end_drop_cnt", 64'(drop_cnt), 64'(exp_drop));
      run_disp(0, 32'h24681357, 0);

      // Reset mid-frame: no pulse, counters cleared, next byte starts fresh
      put_byte(8'h03, 1'b0);
      put_byte(8'h10, 1'b0);
      rst = 1'b1;
      #1;
      check("rst_mid_busy", 64'(busy), 64'd0);
      check("rst_mid_drop", 64'(drop_cnt), 64'd0);
      cyc();
      rst = 1'b0;
      exp_drop = 0;
      cyc();
      run_disp(3, 32'h10203040, 0);

      // Reset mid-DISP: o_valid drops asynchronously
      expect_ev(K_LEN, 0, 32'h0);
      pulse_end();
      drain(8);
      send_frame(8'h02, PL, 32'h99887766, 1'b0, 1'b0);
      cyc();
      check("pre_rst_o_valid", 64'(o_valid), 64'(oh(2)));
      rst = 1'b1;
      #1;
      check("rst_disp_o_valid", 64'(o_valid), 64'd0);
      check("rst_disp_drop", 64'(drop_cnt), 64'd0);
      cyc();
      rst = 1'b0;
      exp_drop = 0;
      cyc();
      run_disp(1, 32'h0A0B0C0D, 2);

`ifdef UDP_DISPATCH_CSUM_EN
      expect_ev(K_CSUM, 1, 32'h0);
      send_frame(8'h01, PL, 32'hAABBCCDD, 1'b1, 1'b0);
      drain(8);
      check("csum_drop_cnt", 64'(drop_cnt), 64'(exp_drop));
      run_disp(1, 32'hAABBCCDD, 0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
